// File: rtl/boot_ctrl.sv
// Boot controller: streams a program into instruction memory, releases the core,
// then watches for a halt icode or a run-cycle budget overrun.
module boot_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 64,
   parameter int MAX_BYTES  = 1024,
   parameter int HALT_MASK  = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [31:0]           run_limit,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  core_rst_n,
   output logic                  core_valid,
   input  logic [3:0]            f_icode_i,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [15:0]           byte_count,
   output logic [31:0]           cycle_count,
   output logic [2:0]            dbg_state_o
);

   // Stream handshake: a byte transfers on a rising edge where s_valid && s_ready;
   // s_ready is registered and is high exactly while the FSM is in LOAD.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_HALTED = 3'd4,
      S_ERROR  = 3'd5
   } state_e;

   localparam logic [15:0] LAST_IDX = 16'(MAX_BYTES - 1);

   state_e                  state_q, state_d;
   logic                    s_ready_q;
   logic                    wr_en_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;
   logic                    core_rst_n_q;
   logic                    core_valid_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    error_q;
   logic [1:0]              err_code_q, err_code_d;
   logic [15:0]             byte_count_q, byte_count_d;
   logic [31:0]             cycle_count_q, cycle_count_d;
   logic                    accept;
   logic                    halt_hit;
   logic                    timeout_hit;

   always_comb begin
      accept        = s_valid && s_ready_q;
      halt_hit      = (f_icode_i == 4'h0) && (cycle_count_q >= 32'(HALT_MASK));
      timeout_hit   = (run_limit != 32'd0) && (cycle_count_q == run_limit - 32'd1);
      state_d       = state_q;
      err_code_d    = err_code_q;
      byte_count_d  = accept ? byte_count_q + 16'd1 : byte_count_q;
      cycle_count_d = cycle_count_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
               if (start) begin
                  state_d       = S_LOAD;
                  err_code_d    = 2'b00;
                  byte_count_d  = 16'd0;
                  cycle_count_d = 32'd0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (s_last) begin
                     state_d = S_SETTLE;
                  end else if (byte_count_q == LAST_IDX) begin
                     state_d    = S_ERROR;
                     err_code_d = 2'b01;
                  end
               end
            end
            S_SETTLE: state_d = S_RUN;
            S_RUN: begin
               if (cycle_count_q != 32'hFFFF_FFFF) cycle_count_d = cycle_count_q + 32'd1;
               // Halt wins over a timeout landing on the same cycle.
               if (halt_hit) begin
                  state_d = S_HALTED;
               end else if (timeout_hit) begin
                  state_d    = S_ERROR;
                  err_code_d = 2'b10;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         s_ready_q     <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         core_rst_n_q  <= 1'b0;
         core_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_code_q    <= 2'b00;
         byte_count_q  <= 16'd0;
         cycle_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         s_ready_q     <= (state_d == S_LOAD);
         core_valid_q  <= (state_d == S_RUN);
         core_rst_n_q  <= (state_d == S_RUN) || (state_d == S_HALTED);
         busy_q        <= (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
         done_q        <= (state_d == S_HALTED);
         error_q       <= (state_d == S_ERROR);
         err_code_q    <= err_code_d;
         byte_count_q  <= byte_count_d;
         cycle_count_q <= cycle_count_d;
         // An accepted byte is always written, even if abort arrives alongside it.
         wr_en_q       <= accept;
         if (accept) begin
            wr_addr_q <= ADDR_WIDTH'(byte_count_q);
            wr_data_q <= s_data;
         end
      end
   end

   assign s_ready     = s_ready_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign core_rst_n  = core_rst_n_q;
   assign core_valid  = core_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_code    = err_code_q;
   assign byte_count  = byte_count_q;
   assign cycle_count = cycle_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: load/run/halt, gapped stream, overflow, timeout,
// abort and asynchronous reset, checked with immediate assertions.
module tb_boot_ctrl;

   localparam int W = 72;

   logic        sys_clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [31:0] run_limit;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [7:0]  wr_data;
   logic        core_rst_n;
   logic        core_valid;
   logic [3:0]  f_icode_i;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [15:0] byte_count;
   logic [31:0] cycle_count;
   logic [2:0]  dbg_state_o;

   int total = 0;
   int bad   = 0;
   int ld_addr = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   boot_ctrl #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(64),
      .MAX_BYTES (8),
      .HALT_MASK (2)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .run_limit  (run_limit),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .core_rst_n (core_rst_n),
      .core_valid (core_valid),
      .f_icode_i  (f_icode_i),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .byte_count (byte_count),
      .cycle_count(cycle_count),
      .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(negedge sys_clk) begin
      if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      ld_addr = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      exp_q.push_back({64'(ld_addr), d});
      ld_addr++;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic gap();
      s_valid = 1'b0;
      s_data  = 8'hFF;
      s_last  = 1'b1;
      tick();
      s_last  = 1'b0;
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      run_limit = 32'd0;
      s_valid   = 1'b0;
      s_data    = 8'h00;
      s_last    = 1'b0;
      f_icode_i = 4'h1;
      tick();
      chk("rst_state",  64'(dbg_state_o), 64'd0);
      chk("rst_sready", 64'(s_ready), 64'd0);
      chk("rst_wren",   64'(wr_en), 64'd0);
      chk("rst_waddr",  wr_addr, 64'd0);
      chk("rst_wdata",  64'(wr_data), 64'd0);
      chk("rst_crst",   64'(core_rst_n), 64'd0);
      chk("rst_cvalid", 64'(core_valid), 64'd0);
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_flags",  64'({done, error, err_code}), 64'd0);
      chk("rst_counts", 64'({byte_count, cycle_count}), 64'd0);
      rst_n = 1'b1;
      tick();

      // basic load, settle, run, halt at cycle 3
      do_start();
      chk("t1_sready", 64'(s_ready), 64'd1);
      chk("t1_busy",   64'(busy), 64'd1);
      send(8'h10, 1'b0);
      send(8'h60, 1'b0);
      send(8'hab, 1'b0);
      send(8'h00, 1'b1);
      chk("t1_settle_state", 64'(dbg_state_o), 64'd2);
      chk("t1_settle_sready", 64'(s_ready), 64'd0);
      chk("t1_settle_crst", 64'(core_rst_n), 64'd0);
      tick();
      chk("t1_run_state", 64'(dbg_state_o), 64'd3);
      chk("t1_run_core", 64'({core_rst_n, core_valid}), 64'd3);
      chk("t1_run_cc0", 64'(cycle_count), 64'd0);
      tick();
      tick();
      tick();
      chk("t1_run_cc3", 64'(cycle_count), 64'd3);
      f_icode_i = 4'h0;
      tick();
      f_icode_i = 4'h1;
      chk("t1_done",   64'(done), 64'd1);
      chk("t1_halt_core", 64'({core_rst_n, core_valid}), 64'd2);
      chk("t1_bytes",  64'(byte_count), 64'd4);
      chk("t1_cc",     64'(cycle_count), 64'd4);
      chk("t1_busy",   64'(busy), 64'd0);
      tick();
      chk("t1_hold",   64'({done, byte_count, cycle_count}), {15'd0, 1'b1, 16'd4, 32'd4});
      check_writes("t1");

      // gapped stream, then abort during RUN
      do_start();
      chk("t2_cleared", 64'({done, byte_count, cycle_count}), 64'd0);
      send(8'h21, 1'b0);
      gap();
      send(8'h22, 1'b0);
      gap();
      send(8'h23, 1'b1);
      chk("t2_settle", 64'(dbg_state_o), 64'd2);
      tick();
      tick();
      tick();
      tick();
      chk("t2_cc3", 64'(cycle_count), 64'd3);
      start = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t2_abort_state", 64'(dbg_state_o), 64'd0);
      chk("t2_abort_core", 64'({core_rst_n, core_valid, busy}), 64'd0);
      check_writes("t2");

      // reload from address 0, masked early halt, then timeout at run_limit=5
      do_start();
      send(8'h55, 1'b0);
      send(8'h66, 1'b1);
      run_limit = 32'd5;
      f_icode_i = 4'h0;
      tick();
      tick();
      tick();
      chk("t3_masked", 64'({dbg_state_o, cycle_count}), {29'd0, 3'd3, 32'd2});
      f_icode_i = 4'h1;
      tick();
      tick();
      tick();
      chk("t3_error", 64'({error, err_code}), 64'h6);
      chk("t3_cc",    64'(cycle_count), 64'd5);
      chk("t3_core",  64'({core_rst_n, core_valid, done}), 64'd0);
      chk("t3_bytes", 64'(byte_count), 64'd2);
      check_writes("t3");

      // halt and timeout on the same cycle: halt wins
      do_start();
      chk("t4_errclr", 64'({error, err_code}), 64'd0);
      send(8'h77, 1'b1);
      run_limit = 32'd3;
      tick();
      tick();
      tick();
      f_icode_i = 4'h0;
      tick();
      f_icode_i = 4'h1;
      chk("t4_prio", 64'({done, error, err_code}), 64'h8);
      chk("t4_cc",   64'(cycle_count), 64'd3);
      check_writes("t4");
      run_limit = 32'd0;

      // overflow: 8 bytes without s_last on an 8-byte program store
      do_start();
      for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0);
      chk("t5_error",  64'({error, err_code}), 64'h5);
      chk("t5_sready", 64'(s_ready), 64'd0);
      chk("t5_bytes",  64'(byte_count), 64'd8);
      tick();
      check_writes("t5");

      // asynchronous reset in the middle of a load
      do_start();
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      tick();
      s_valid = 1'b1;
      s_data  = 8'h33;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async", 64'({s_ready, wr_en, busy, core_rst_n, byte_count}), 64'd0);
      chk("t6_state", 64'(dbg_state_o), 64'd0);
      tick();
      tick();
      chk("t6_still", 64'({s_ready, wr_en, byte_count}), 64'd0);
      check_writes("t6");
      s_valid = 1'b0;
      rst_n   = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
